// File: rtl/stream_filter_cfg.sv
// Config-bus address map shared by stream_filter and its downstream stream_pack.
package stream_filter_cfg;

  localparam int unsigned CFG_WIDTH   = 1;
  localparam int unsigned CFG_KERNEL  = 2;
  localparam int unsigned CFG_RESCALE = 3;
  localparam int unsigned CFG_FRAME   = 4;

  // Width of an index into n items; never zero, so it stays usable for n == 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word.
// The occupancy count covers both the memory and the head register.
module fifo_fwft #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_din,
  input  logic              i_pop,
  output logic              o_full_c,
  output logic              o_empty_c,
  output logic [DWIDTH-1:0] o_head,
  output logic              o_valid
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned CWIDTH = AWIDTH + 1;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [CWIDTH-1:0] r_count;

  logic              w_pop;
  logic              w_push_ok;
  logic              w_load;
  logic [CWIDTH-1:0] w_mem_cnt;

  assign w_pop     = o_valid & i_pop;
  assign o_full_c  = (r_count == CWIDTH'(DEPTH));
  assign o_empty_c = ~o_valid;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_push_ok = i_push & (~o_full_c | w_pop);
  assign w_mem_cnt = r_count - CWIDTH'(o_valid);
  // Refill the head register from memory when it is empty or being consumed.
  assign w_load    = (w_mem_cnt != '0) & (~o_valid | w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_head   <= '0;
      o_valid  <= 1'b0;
    end else begin
      r_count <= r_count + CWIDTH'(w_push_ok) - CWIDTH'(w_pop);
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      end
      if (w_load) begin
        o_head   <= r_mem[r_rd_ptr];
        o_valid  <= 1'b1;
        r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      end else if (w_pop) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_pack.sv
// Packs PACK_NB consecutive filter results into one wide word, marks frame ends,
// and buffers words in a FIFO; a full FIFO drops words and sets a sticky overflow.
module stream_pack
  import stream_filter_cfg::*;
#(
  parameter int unsigned CFG_DWIDTH  = 32,
  parameter int unsigned CFG_AWIDTH  = 5,
  parameter int unsigned IMG_WIDTH   = 16,
  parameter int unsigned PACK_NB     = 4,
  parameter int unsigned FIFO_AWIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CFG_DWIDTH-1:0]        cfg_data,
  input  logic [CFG_AWIDTH-1:0]        cfg_addr,
  input  logic                         cfg_valid,
  input  logic [IMG_WIDTH-1:0]         up_data,
  input  logic                         up_val,
  output logic [IMG_WIDTH*PACK_NB-1:0] dn_data,
  output logic [PACK_NB-1:0]           dn_keep,
  output logic                         dn_last,
  output logic                         dn_valid,
  input  logic                         dn_ready,
  output logic                         overflow
);

  localparam int unsigned DWORD  = IMG_WIDTH * PACK_NB;
  localparam int unsigned FWIDTH = DWORD + PACK_NB + 1;
  localparam int unsigned LWIDTH = idx_width(PACK_NB);
  localparam logic [LWIDTH-1:0] LAST_LANE = LWIDTH'(PACK_NB - 1);

  logic [CNT_WIDTH-1:0] r_frame_len;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [LWIDTH-1:0]    r_lane_idx;
  logic [DWORD-1:0]     r_data;
  logic [PACK_NB-1:0]   r_keep;
  logic                 r_push_vld;
  logic [FWIDTH-1:0]    r_push_word;
  logic                 r_overflow;

  logic                 w_cfg_frame;
  logic                 w_lane_full;
  logic                 w_frame_end;
  logic [DWORD-1:0]     w_lane_data;
  logic [PACK_NB-1:0]   w_lane_keep;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [FWIDTH-1:0]    w_head;

  if (CFG_DWIDTH > CNT_WIDTH) begin : g_cfg_unused
    logic w_unused_cfg;
    assign w_unused_cfg = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
  end

  assign w_cfg_frame = cfg_valid & (cfg_addr == CFG_AWIDTH'(CFG_FRAME));
  assign w_lane_full = (r_lane_idx == LAST_LANE);
  assign w_frame_end = (r_frame_len != '0) && (r_frame_cnt == r_frame_len - CNT_WIDTH'(1));

  // Current partial word with the incoming result merged into its lane.
  always_comb begin
    w_lane_data = r_data;
    w_lane_keep = r_keep;
    w_lane_data[r_lane_idx*IMG_WIDTH +: IMG_WIDTH] = up_data;
    w_lane_keep[r_lane_idx] = 1'b1;
  end

  assign w_pop  = dn_ready & ~w_fifo_empty;
  assign w_drop = r_push_vld & w_fifo_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_len <= '0;
      r_frame_cnt <= '0;
      r_lane_idx  <= '0;
      r_data      <= '0;
      r_keep      <= '0;
      r_push_vld  <= 1'b0;
      r_push_word <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_push_vld <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      // A frame-length write restarts packing and takes priority over a result.
      if (w_cfg_frame) begin
        r_frame_len <= cfg_data[CNT_WIDTH-1:0];
        r_frame_cnt <= '0;
        r_lane_idx  <= '0;
        r_data      <= '0;
        r_keep      <= '0;
        r_overflow  <= 1'b0;
      end else if (up_val) begin
        if (w_lane_full | w_frame_end) begin
          r_push_vld  <= 1'b1;
          r_push_word <= {w_lane_data, w_lane_keep, w_frame_end};
          r_lane_idx  <= '0;
          r_data      <= '0;
          r_keep      <= '0;
          r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + CNT_WIDTH'(1);
        end else begin
          r_lane_idx  <= r_lane_idx + LWIDTH'(1);
          r_data      <= w_lane_data;
          r_keep      <= w_lane_keep;
          r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  fifo_fwft #(
    .DWIDTH (FWIDTH),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (r_push_vld),
    .i_din     (r_push_word),
    .i_pop     (dn_ready),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty),
    .o_head    (w_head),
    .o_valid   (dn_valid)
  );

  assign {dn_data, dn_keep, dn_last} = w_head;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_stream_pack.sv
// Directed bench for stream_pack: table of packing/framing cases plus hand-written
// latency, backpressure, overflow, push-at-full, config-priority and reset sequences.
module tb_stream_pack;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned IW  = 16;
  localparam int unsigned NB  = 4;
  localparam int unsigned FAW = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned WW  = IW * NB + NB + 1;

  typedef logic [WW-1:0] word_t;

  typedef struct {
    logic [15:0] frame_len;
    int          nres;
    logic [15:0] base;
    int          nwords;
    logic [63:0] d0;
    logic [3:0]  k0;
    logic        l0;
    logic [63:0] d1;
    logic [3:0]  k1;
    logic        l1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cfg_data;
  logic [AW-1:0] cfg_addr;
  logic          cfg_valid;
  logic [IW-1:0] up_data;
  logic          up_val;
  logic [IW*NB-1:0] dn_data;
  logic [NB-1:0] dn_keep;
  logic          dn_last;
  logic          dn_valid;
  logic          dn_ready;
  logic          overflow;

  int    n_pass;
  int    n_total;
  word_t got[$];
  vec_t  vec[7];

  always #5 clk = ~clk;

  stream_pack #(
    .CFG_DWIDTH  (DW),
    .CFG_AWIDTH  (AW),
    .IMG_WIDTH   (IW),
    .PACK_NB     (NB),
    .FIFO_AWIDTH (FAW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_valid (cfg_valid),
    .up_data   (up_data),
    .up_val    (up_val),
    .dn_data   (dn_data),
    .dn_keep   (dn_keep),
    .dn_last   (dn_last),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Record any word consumed at the coming edge, then advance to just after it.
  task automatic step();
    if (dn_valid && dn_ready) got.push_back({dn_data, dn_keep, dn_last});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] v);
    up_val  = 1'b1;
    up_data = v;
    step();
    up_val  = 1'b0;
  endtask

  function automatic word_t mkword(input logic [63:0] d, input logic [3:0] k, input logic l);
    return {d, k, l};
  endfunction

  // Full word of four consecutive results starting at v (lane 0 = v).
  function automatic word_t lanes(input logic [15:0] v);
    return {v + 16'd3, v + 16'd2, v + 16'd1, v, 4'hF, 1'b0};
  endfunction

  function automatic word_t cur_word();
    return {dn_data, dn_keep, dn_last};
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    vec[0] = '{16'd0, 8, 16'h0001, 2, 64'h0004_0003_0002_0001, 4'hF, 1'b0,
               64'h0008_0007_0006_0005, 4'hF, 1'b0};
    vec[1] = '{16'd6, 6, 16'h0001, 2, 64'h0004_0003_0002_0001, 4'hF, 1'b0,
               64'h0000_0000_0006_0005, 4'h3, 1'b1};
    vec[2] = '{16'd0, 5, 16'h0040, 1, 64'h0043_0042_0041_0040, 4'hF, 1'b0,
               64'h0, 4'h0, 1'b0};
    vec[3] = '{16'd1, 2, 16'h0100, 2, 64'h0000_0000_0000_0100, 4'h1, 1'b1,
               64'h0000_0000_0000_0101, 4'h1, 1'b1};
    vec[4] = '{16'd3, 6, 16'h000A, 2, 64'h0000_000C_000B_000A, 4'h7, 1'b1,
               64'h0000_000F_000E_000D, 4'h7, 1'b1};
    vec[5] = '{16'd5, 5, 16'h0020, 2, 64'h0023_0022_0021_0020, 4'hF, 1'b0,
               64'h0000_0000_0000_0024, 4'h1, 1'b1};
    vec[6] = '{16'd4, 8, 16'h0030, 2, 64'h0033_0032_0031_0030, 4'hF, 1'b1,
               64'h0037_0036_0035_0034, 4'hF, 1'b1};

    rst = 1'b1; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
    up_data = '0; up_val = 1'b0; dn_ready = 1'b0;
    idle(2);
    check("rst_valid", 128'(dn_valid), 128'(0));
    check("rst_word", 128'(cur_word()), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    rst = 1'b0;
    idle(1);

    // First-word latency: valid appears two edges after the closing result.
    for (int i = 1; i <= 3; i++) send(16'(i));
    send(16'd4);
    check("lat_k", 128'(dn_valid), 128'(0));
    step();
    check("lat_k1", 128'(dn_valid), 128'(0));
    step();
    check("lat_k2_valid", 128'(dn_valid), 128'(1));
    check("lat_k2_word", 128'(cur_word()), 128'(lanes(16'd1)));
    dn_ready = 1'b1;
    idle(3);

    for (int c = 0; c < 7; c++) begin
      dn_ready = 1'b1;
      got.delete();
      cfg_write(AW'(4), DW'(vec[c].frame_len));
      for (int i = 0; i < vec[c].nres; i++) send(vec[c].base + 16'(i));
      idle(6);
      check($sformatf("vec%0d_count", c), 128'(got.size()), 128'(vec[c].nwords));
      if (vec[c].nwords > 0)
        check($sformatf("vec%0d_word0", c), 128'(got[0]), 128'(mkword(vec[c].d0, vec[c].k0, vec[c].l0)));
      if (vec[c].nwords > 1)
        check($sformatf("vec%0d_word1", c), 128'(got[1]), 128'(mkword(vec[c].d1, vec[c].k1, vec[c].l1)));
    end

    // Config write beats a simultaneous result; other addresses leave packing alone.
    got.delete();
    cfg_valid = 1'b1; cfg_addr = AW'(4); cfg_data = '0;
    up_val = 1'b1; up_data = 16'hDEAD;
    step();
    cfg_valid = 1'b0; up_val = 1'b0;
    send(16'd1); send(16'd2);
    cfg_write(AW'(2), DW'(9));
    send(16'd3); send(16'd4);
    idle(5);
    check("cfgwin_count", 128'(got.size()), 128'(1));
    check("cfgwin_word", 128'(got[0]), 128'(lanes(16'd1)));

    // Backpressure: sixteen words fill the FIFO exactly, then drain in order.
    got.delete();
    dn_ready = 1'b0;
    cfg_write(AW'(4), DW'(0));
    for (int i = 1; i <= 64; i++) send(16'(i));
    idle(3);
    check("bp_valid", 128'(dn_valid), 128'(1));
    for (int i = 0; i < 4; i++) begin
      check("bp_stable", 128'(cur_word()), 128'(lanes(16'd1)));
      step();
    end
    dn_ready = 1'b1;
    idle(20);
    check("bp_count", 128'(got.size()), 128'(16));
    for (int j = 0; j < 16; j++)
      check($sformatf("bp_word%0d", j), 128'(got[j]), 128'(lanes(16'(4 * j + 1))));
    check("bp_overflow", 128'(overflow), 128'(0));

    // Overflow: the seventeenth word is dropped and overflow rises after its push.
    got.delete();
    dn_ready = 1'b0;
    cfg_write(AW'(4), DW'(0));
    for (int i = 1; i <= 67; i++) send(16'(i));
    send(16'd68);
    check("ovf_before", 128'(overflow), 128'(0));
    step();
    check("ovf_rise", 128'(overflow), 128'(1));
    dn_ready = 1'b1;
    idle(20);
    check("ovf_count", 128'(got.size()), 128'(16));
    check("ovf_lastword", 128'(got[15]), 128'(lanes(16'd61)));
    check("ovf_sticky", 128'(overflow), 128'(1));
    cfg_write(AW'(4), DW'(0));
    check("ovf_clear", 128'(overflow), 128'(0));

    // Push at full with a pop in the same cycle is accepted.
    got.delete();
    dn_ready = 1'b0;
    for (int i = 1; i <= 67; i++) send(16'(i));
    up_val = 1'b1; up_data = 16'd68;
    step();
    up_val = 1'b0;
    dn_ready = 1'b1;
    step();
    check("pp_overflow", 128'(overflow), 128'(0));
    idle(20);
    check("pp_count", 128'(got.size()), 128'(17));
    check("pp_first", 128'(got[0]), 128'(lanes(16'd1)));
    check("pp_last", 128'(got[16]), 128'(lanes(16'd65)));
    check("pp_overflow_end", 128'(overflow), 128'(0));

    // Reset mid-frame with three words buffered and a partial word in lane 2.
    got.delete();
    dn_ready = 1'b0;
    cfg_write(AW'(4), DW'(7));
    for (int i = 1; i <= 13; i++) send(16'(i));
    idle(4);
    check("rstm_pre_valid", 128'(dn_valid), 128'(1));
    rst = 1'b1;
    step();
    check("rstm_valid", 128'(dn_valid), 128'(0));
    check("rstm_word", 128'(cur_word()), 128'(0));
    check("rstm_overflow", 128'(overflow), 128'(0));
    rst = 1'b0;
    got.delete();
    dn_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(16'h51 + 16'(i));
    idle(6);
    check("rstm_count", 128'(got.size()), 128'(1));
    check("rstm_word0", 128'(got[0]), 128'(lanes(16'h51)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
